// File: rtl/axi_lite_fifo_regs_if.sv
// AXI4-Lite bus bundle between the manager and the FIFO register block.
interface axi_lite_fifo_regs_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_fifo_regs.sv
// AXI4-Lite register block: CTRL.flush (0x00) and synchronised FIFO empty/full STATUS (0x01).
module axi_lite_fifo_regs #(
  parameter int   ADDR_W      = 8,
  parameter int   DATA_W      = 8,
  parameter logic FLUSH_RST   = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  axi_lite_fifo_regs_if.slave     bus,
  input  logic                    fifo_empty,
  input  logic                    fifo_full,
  output logic                    flush
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              wbit_q, wbit_d;
  logic              wstrb0_q, wstrb0_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [SYNC_STAGES-1:0] empty_sync_q, empty_sync_d;
  logic [SYNC_STAGES-1:0] full_sync_q, full_sync_d;

  logic              aw_hs, w_hs;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bit, wr_strb0;

  assign flush      = flush_q;
  assign bus.bvalid = (w_state_q == W_RESP);
  assign bus.bresp  = bresp_q;
  assign bus.rvalid = (r_state_q == R_RESP);
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;

  always_comb begin
    empty_sync_d = {empty_sync_q[SYNC_STAGES-2:0], fifo_empty};
    full_sync_d  = {full_sync_q[SYNC_STAGES-2:0], fifo_full};
  end

  // Write path: AW and W are captured independently; commit once both are present,
  // using the live bus values for whichever arrives on the commit edge.
  always_comb begin
    w_state_d   = w_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wbit_d      = wbit_q;
    wstrb0_d    = wstrb0_q;
    bresp_d     = bresp_q;
    flush_d     = flush_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    wr_addr     = aw_held_q ? awaddr_q : bus.awaddr;
    wr_bit      = w_held_q ? wbit_q : bus.wdata[0];
    wr_strb0    = w_held_q ? wstrb0_q : bus.wstrb[0];
    case (w_state_q)
      W_IDLE: begin
        bus.awready = !aw_held_q;
        bus.wready  = !w_held_q;
        aw_hs       = bus.awvalid && !aw_held_q;
        w_hs        = bus.wvalid && !w_held_q;
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = bus.awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wbit_d   = bus.wdata[0];
          wstrb0_d = bus.wstrb[0];
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_d = W_RESP;
          if (wr_addr == ADDR_W'(0)) begin
            bresp_d = RESP_OKAY;
            if (wr_strb0) flush_d = wr_bit;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path samples flush_q before any same-cycle write lands, so reads see the old CTRL.
  always_comb begin
    r_state_d   = r_state_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bus.arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        bus.arready = 1'b1;
        if (bus.arvalid) begin
          r_state_d = R_RESP;
          if (bus.araddr == ADDR_W'(0)) begin
            rdata_d = DATA_W'(flush_q);
            rresp_d = RESP_OKAY;
          end else if (bus.araddr == ADDR_W'(1)) begin
            rdata_d = DATA_W'({full_sync_q[SYNC_STAGES-1], empty_sync_q[SYNC_STAGES-1]});
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_RESP: if (bus.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wbit_q       <= 1'b0;
      wstrb0_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      flush_q      <= FLUSH_RST;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      empty_sync_q <= '0;
      full_sync_q  <= '0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wbit_q       <= wbit_d;
      wstrb0_q     <= wstrb0_d;
      bresp_q      <= bresp_d;
      flush_q      <= flush_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      empty_sync_q <= empty_sync_d;
      full_sync_q  <= full_sync_d;
    end
  end
endmodule
